// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, consumer handshake and status signals of the uart receiver
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 RxD;
    logic                 data_ack;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_err;
    logic                 overrun;
    logic                 busy;

    // Line driver and byte consumer side
    modport master (
        output RxD,
        output data_ack,
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  overrun,
        input  busy
    );

    // Receiver side
    modport slave (
        input  RxD,
        input  data_ack,
        output data_out,
        output data_valid,
        output framing_err,
        output overrun,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 uart receiver with mid-bit sampling, single byte holding register and error flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t               state_q,    state_d;
    logic                 meta_q;
    logic                 rxs_q;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q,    valid_d;
    logic                 ovr_q,      ovr_d;
    logic                 ferr_q,     ferr_d;

    logic                 bit_end;
    logic                 accept;
    logic                 frame_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= bus.RxD;
            rxs_q  <= meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start qualification at half bit, data and stop sampling at full bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST && bit_idx_q == IDX_LAST) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // A held-low line (break) must go high before a new start is looked for
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bit timing, shifting, byte hand-off and error flags
    always_comb begin
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        bit_end    = (cnt_q == CNT_LAST);
        accept     = (state_q == S_STOP) && bit_end && rxs_q;
        frame_bad  = (state_q == S_STOP) && bit_end && !rxs_q;
        ferr_d     = frame_bad;
        bus.busy   = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                // bit_index restarts here so every frame fills from the LSB
                bit_idx_d = '0;
                cnt_d     = (cnt_q == CNT_HALF) ? '0 : cnt_q + CNT_ONE;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d[bit_idx_q] = rxs_q;
                    bit_idx_d          = bit_idx_q + IDX_ONE;
                    cnt_d              = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
        endcase

        // An ack in the acceptance cycle frees the holding register for the new byte
        if (accept) begin
            if (!valid_q || bus.data_ack) begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.data_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = valid_q;
    assign bus.overrun     = ovr_q;
    assign bus.framing_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed vectors, corner sequences, random frames vs frame-level model
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB       = 16;
    localparam int FRAME_CYC = 10 * CPB;
    // 2 synchronizer edges + 1 into START, half bit, 8 data bits + stop bit
    localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack_acc;
        logic       ack_after;
        logic [7:0] exp_out;
        logic       exp_dv;
        logic       exp_ov;
        logic       chk_lat;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame; edge c (1-based) is the rising edge following the drive in iteration c
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_c,
                              output logic dv_before, output logic dv_after,
                              output logic busy_after, output int fe_cnt);
        int idx;
        fe_cnt     = 0;
        dv_before  = 1'bx;
        dv_after   = 1'bx;
        busy_after = 1'bx;
        for (int c = 1; c <= FRAME_CYC; c++) begin
            @(negedge clk);
            if (bus.framing_err) fe_cnt++;
            if (c == STOP_EDGE) dv_before = bus.data_valid;
            if (c == STOP_EDGE + 1) begin
                dv_after   = bus.data_valid;
                busy_after = bus.busy;
            end
            idx = (c - 1) / CPB;
            if (idx == 0)      bus.RxD = 1'b0;
            else if (idx == 9) bus.RxD = stop;
            else               bus.RxD = d[idx-1];
            bus.data_ack = (c == ack_c);
        end
    endtask

    task automatic idle(input int n, input int ack_i, output int fe_cnt);
        fe_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.framing_err) fe_cnt++;
            bus.RxD      = 1'b1;
            bus.data_ack = (i == ack_i);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       dvb, dva, bsa, busy_all, busy_seen, flags_seen;
        int         fe, fe2;
        logic [7:0] m_held;
        logic       m_hv, m_ov;
        logic [7:0] rd;
        logic       rstop, rack, gack;
        int         gap;

        bus.RxD      = 1'b1;
        bus.data_ack = 1'b0;

        vt[0] = '{8'h35, 1'b0, 1'b1, 8'h35, 1'b1, 1'b0, 1'b1};
        vt[1] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        vt[2] = '{8'h02, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
        vt[3] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1};
        vt[4] = '{8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_data_out", bus.data_out, 8'h00);
        check("reset_outputs", {bus.data_valid, bus.framing_err, bus.overrun, bus.busy}, 4'b0000);
        rst = 1'b1;
        idle(5, -1, fe);

        // Directed frames
        for (int v = 0; v < 5; v++) begin
            send_frame(vt[v].data, 1'b1, vt[v].ack_acc ? STOP_EDGE : -1, dvb, dva, bsa, fe);
            if (vt[v].chk_lat) check($sformatf("v%0d_dv_before_stop", v), dvb, 1'b0);
            check($sformatf("v%0d_dv_after_stop", v), dva, vt[v].exp_dv);
            check($sformatf("v%0d_busy_after", v), bsa, 1'b0);
            idle(4, -1, fe2);
            check($sformatf("v%0d_fe_count", v), fe + fe2, 0);
            check($sformatf("v%0d_data_out", v), bus.data_out, vt[v].exp_out);
            check($sformatf("v%0d_dv", v), bus.data_valid, vt[v].exp_dv);
            check($sformatf("v%0d_ov", v), bus.overrun, vt[v].exp_ov);
            if (vt[v].ack_after) begin
                idle(6, 2, fe2);
                check($sformatf("v%0d_ack_clear", v), {bus.data_valid, bus.overrun}, 2'b00);
            end
        end

        // Bad stop bit followed by a 40-cycle break
        send_frame(8'hA5, 1'b0, -1, dvb, dva, bsa, fe);
        check("ferr_dv_after", dva, 1'b0);
        check("ferr_busy_after", bsa, 1'b1);
        busy_all = 1'b1;
        fe2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.framing_err) fe2++;
            if (!bus.busy) busy_all = 1'b0;
            bus.RxD = 1'b0;
        end
        check("ferr_pulse_count", fe + fe2, 1);
        check("ferr_wait_high_busy", busy_all, 1'b1);
        check("ferr_dv_ov", {bus.data_valid, bus.overrun}, 2'b00);
        check("ferr_data_out_kept", bus.data_out, 8'h02);
        bus.RxD = 1'b1;
        for (int i = 0; i < 8 && bus.busy; i++) @(negedge clk);
        check("ferr_release_idle", bus.busy, 1'b0);

        // Start-bit glitch
        busy_seen  = 1'b0;
        flags_seen = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.data_valid || bus.framing_err || bus.overrun) flags_seen = 1'b1;
            bus.RxD = (i < 4) ? 1'b0 : 1'b1;
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_back_idle", bus.busy, 1'b0);
        check("glitch_no_flags", flags_seen, 1'b0);

        // Reset in the middle of bit 4 of 0xFF
        for (int c = 1; c <= 4 * CPB + CPB + CPB / 2; c++) begin
            @(negedge clk);
            bus.RxD = (c <= CPB) ? 1'b0 : 1'b1;
        end
        check("pre_reset_busy", bus.busy, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_data_out", bus.data_out, 8'h00);
        check("midreset_outputs", {bus.data_valid, bus.framing_err, bus.overrun, bus.busy}, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(6, -1, fe);
        check("post_reset_no_start", bus.busy, 1'b0);
        send_frame(8'h3C, 1'b1, -1, dvb, dva, bsa, fe);
        idle(4, -1, fe2);
        check("post_reset_data_out", bus.data_out, 8'h3C);
        check("post_reset_flags", {bus.data_valid, bus.overrun, 1'(fe + fe2 != 0)}, 3'b100);

        // Random frames against a frame-level model of the holding register
        m_held = 8'h3C;
        m_hv   = 1'b1;
        m_ov   = 1'b0;
        for (int n = 0; n < 30; n++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rack  = ($urandom_range(0, 3) == 0);
            gack  = ($urandom_range(0, 2) == 0);
            gap   = $urandom_range(4, 20);
            send_frame(rd, rstop, rack ? STOP_EDGE : -1, dvb, dva, bsa, fe);
            if (rstop) begin
                if (!m_hv || rack) begin
                    m_held = rd;
                    m_hv   = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (rack && m_hv) begin
                m_hv = 1'b0;
                m_ov = 1'b0;
            end
            check($sformatf("rnd%0d_fe_count", n), fe, rstop ? 0 : 1);
            idle(gap, gack ? 1 : -1, fe2);
            if (gack && m_hv) begin
                m_hv = 1'b0;
                m_ov = 1'b0;
            end
            check($sformatf("rnd%0d_data_out", n), bus.data_out, m_held);
            check($sformatf("rnd%0d_dv_ov", n), {bus.data_valid, bus.overrun}, {m_hv, m_ov});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
